msplit_arb: RTL and testbench

MSPLIT_ARB -- requirements
Module: msplit_arb

---
 rtl/msplit_arb_if.sv | 15 +
 rtl/msplit_arb.sv | 132 +++++++++++++
 tb/tb_msplit_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/msplit_arb_if.sv
// MemSplit32: split-transaction memory port. The request side carries req/we/addr/be/wdata,
// and the response side returns ack for the request plus an in-order resp/rdata for reads.
interface MemSplit32;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ack;
   logic        resp;
   logic [31:0] rdata;

   modport Master (output req, we, addr, be, wdata, input ack, resp, rdata);
   modport Slave  (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/msplit_arb.sv
// Two-requester round-robin arbiter onto one MemSplit32 slave.
// A small owner FIFO routes in-order read responses back to the requester that issued each read.
module msplit_arb #(
   parameter int RESP_DEPTH = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   MemSplit32.Slave                    m0,
   MemSplit32.Slave                    m1,
   MemSplit32.Master                   slv,
   output logic [$clog2(RESP_DEPTH):0] occ_o,
   output logic                        err_o
);
   localparam int PW = $clog2(RESP_DEPTH);
   localparam logic [PW:0] FullOcc = (PW+1)'(RESP_DEPTH);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t         r_state;
   logic           r_rr;
   logic [PW-1:0]  r_wrPtr;
   logic [PW-1:0]  r_rdPtr;
   logic [PW:0]    r_occ;
   logic           r_err;
   logic           r_owner [RESP_DEPTH];

   state_t         w_state;
   logic           w_rr;
   logic [PW:0]    w_occ;
   logic           w_full;
   logic           w_elig0;
   logic           w_elig1;
   logic           w_gntValid;
   logic           w_gnt;
   logic           w_we;
   logic           w_accept;
   logic           w_pushRd;
   logic           w_pop;
   logic           w_head;

   // While reset is held, the combinational paths behave as if the registers already held their reset values.
   always_comb begin
      w_state    = rst_i ? IDLE : r_state;
      w_rr       = rst_i ? 1'b0 : r_rr;
      w_occ      = rst_i ? '0 : r_occ;
      w_full     = (w_occ == FullOcc);
      w_elig0    = m0.req & (m0.we | ~w_full);
      w_elig1    = m1.req & (m1.we | ~w_full);
      w_gntValid = 1'b0;
      w_gnt      = 1'b0;
      case (w_state)
         IDLE: begin
            w_gntValid = w_elig0 | w_elig1;
            w_gnt      = (w_elig0 & w_elig1) ? w_rr : ~w_elig0;
         end
         LOCK0: begin
            w_gntValid = m0.req;
            w_gnt      = 1'b0;
         end
         LOCK1: begin
            w_gntValid = m1.req;
            w_gnt      = 1'b1;
         end
         default: begin
            w_gntValid = 1'b0;
            w_gnt      = 1'b0;
         end
      endcase

      w_we      = w_gnt ? m1.we : m0.we;
      slv.req   = w_gntValid;
      slv.we    = w_gntValid & w_we;
      slv.addr  = w_gntValid ? (w_gnt ? m1.addr : m0.addr) : 32'h0;
      slv.be    = w_gntValid ? (w_gnt ? m1.be : m0.be) : 4'h0;
      slv.wdata = w_gntValid ? (w_gnt ? m1.wdata : m0.wdata) : 32'h0;

      w_accept  = w_gntValid & slv.ack;
      m0.ack    = w_accept & ~w_gnt;
      m1.ack    = w_accept & w_gnt;
      w_pushRd  = w_accept & ~w_we;

      w_pop     = slv.resp & (w_occ != '0);
      w_head    = r_owner[r_rdPtr];
      m0.resp   = w_pop & ~w_head;
      m1.resp   = w_pop & w_head;
      m0.rdata  = (w_pop & ~w_head) ? slv.rdata : 32'h0;
      m1.rdata  = (w_pop & w_head) ? slv.rdata : 32'h0;
   end

   // Arbitration state, round-robin pointer, FIFO pointers and the sticky error flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_rr    <= 1'b0;
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_occ   <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_rr    <= ~w_gnt;
            r_state <= IDLE;
         end else if (r_state == IDLE && w_gntValid) begin
            r_state <= w_gnt ? LOCK1 : LOCK0;
         end else if (r_state != IDLE && !w_gntValid) begin
            r_state <= IDLE;
         end

         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_pushRd) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         r_occ <= r_occ + {{PW{1'b0}}, w_pushRd} - {{PW{1'b0}}, w_pop};

         if (slv.resp && r_occ == '0) begin
            r_err <= 1'b1;
         end
      end
   end

   // Owner storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_pushRd) begin
         r_owner[r_wrPtr] <= w_gnt;
      end
   end

   assign occ_o = r_occ;
   assign err_o = r_err;
endmodule

// File: tb/tb_msplit_arb.sv
// Bench for msplit_arb: directed vectors, with accepted requests and routed read responses
// checked by monitor processes against queues of expected transactions.
module tb_msplit_arb;
   logic       clk;
   logic       rst;
   logic [2:0] occ;
   logic       err;
   int         checkCount;
   int         passCount;

   typedef struct {
      logic        owner;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } acc_t;

   typedef struct {
      logic        owner;
      logic [31:0] data;
   } rsp_t;

   acc_t accQ[$];
   rsp_t rspQ[$];

   MemSplit32 m0If();
   MemSplit32 m1If();
   MemSplit32 slvIf();

   msplit_arb #(.RESP_DEPTH(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .m0    (m0If),
      .m1    (m1If),
      .slv   (slvIf),
      .occ_o (occ),
      .err_o (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit port, input logic req, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (port) begin
         m1If.req = req; m1If.we = we; m1If.addr = addr; m1If.be = 4'hF; m1If.wdata = wdata;
      end else begin
         m0If.req = req; m0If.we = we; m0If.addr = addr; m0If.be = 4'hF; m0If.wdata = wdata;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every downstream handshake must match the next expected acceptance, including which requester got ack.
   always @(negedge clk) begin
      if (slvIf.req && slvIf.ack) begin
         if (accQ.size() == 0) begin
            checkOutput("unexpected accept", {slvIf.addr}, 128'h0);
         end else begin
            acc_t e;
            e = accQ.pop_front();
            checkOutput("accept", {m1If.ack, m0If.ack, slvIf.we, slvIf.addr, slvIf.wdata},
                        {e.owner, ~e.owner, e.we, e.addr, e.wdata});
         end
      end
   end

   // Any response seen by a requester must match the next expected owner and data; the other side must be quiet.
   always @(negedge clk) begin
      if (m0If.resp || m1If.resp) begin
         if (rspQ.size() == 0) begin
            checkOutput("unexpected resp", {m1If.resp, m0If.resp}, 128'h0);
         end else begin
            rsp_t r;
            r = rspQ.pop_front();
            checkOutput("resp route", {m1If.resp, m0If.resp, m1If.rdata, m0If.rdata},
                        {r.owner, ~r.owner, (r.owner ? r.data : 32'h0), (r.owner ? 32'h0 : r.data)});
         end
      end
   end

   initial begin
      checkCount = 0;
      passCount  = 0;
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      slvIf.ack   = 1'b0;
      slvIf.resp  = 1'b0;
      slvIf.rdata = 32'h0;
      rst = 1'b1;
      step();
      checkOutput("reset occ", occ, 0);
      checkOutput("reset err", err, 0);
      checkOutput("reset slv req", slvIf.req, 0);
      rst = 1'b0;

      // Simultaneous reads: m0 first, then m1; responses return in order.
      slvIf.ack = 1'b1;
      applyStimulus(0, 1, 0, 32'h100, 0);
      applyStimulus(1, 1, 0, 32'h104, 0);
      accQ.push_back('{1'b0, 1'b0, 32'h100, 32'h0});
      accQ.push_back('{1'b1, 1'b0, 32'h104, 32'h0});
      step();
      checkOutput("dual occ 1", occ, 1);
      applyStimulus(0, 0, 0, 0, 0);
      step();
      checkOutput("dual occ 2", occ, 2);
      applyStimulus(1, 0, 0, 0, 0);
      slvIf.resp = 1'b1; slvIf.rdata = 32'hA0;
      rspQ.push_back('{1'b0, 32'hA0});
      step();
      checkOutput("dual occ 1b", occ, 1);
      slvIf.rdata = 32'hB1;
      rspQ.push_back('{1'b1, 32'hB1});
      step();
      slvIf.resp = 1'b0;
      checkOutput("dual occ 0", occ, 0);

      // Locked write from m1 while m0 starts requesting.
      slvIf.ack = 1'b0;
      applyStimulus(1, 1, 1, 32'h200, 32'hDEADBEEF);
      accQ.push_back('{1'b1, 1'b1, 32'h200, 32'hDEADBEEF});
      step();
      applyStimulus(0, 1, 0, 32'h300, 0);
      accQ.push_back('{1'b0, 1'b0, 32'h300, 32'h0});
      #1;
      checkOutput("lock hold 1", {slvIf.req, slvIf.addr, slvIf.wdata}, {1'b1, 32'h200, 32'hDEADBEEF});
      step();
      #1;
      checkOutput("lock hold 2", {slvIf.req, slvIf.addr, slvIf.wdata}, {1'b1, 32'h200, 32'hDEADBEEF});
      step();
      slvIf.ack = 1'b1;
      step();
      applyStimulus(1, 0, 0, 0, 0);
      step();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("lock occ", occ, 1);
      slvIf.resp = 1'b1; slvIf.rdata = 32'h55;
      rspQ.push_back('{1'b0, 32'h55});
      step();
      slvIf.resp = 1'b0;
      checkOutput("lock drain occ", occ, 0);

      // Fill the owner FIFO; a further read is held off but a write still goes through.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 0, 32'h400 + 32'(4 * i), 0);
         accQ.push_back('{1'b0, 1'b0, 32'h400 + 32'(4 * i), 32'h0});
         step();
      end
      checkOutput("full occ", occ, 4);
      applyStimulus(0, 1, 0, 32'h410, 0);
      #1;
      checkOutput("full holdoff", slvIf.req, 0);
      step();
      checkOutput("full occ hold", occ, 4);
      applyStimulus(1, 1, 1, 32'h600, 32'h12345678);
      accQ.push_back('{1'b1, 1'b1, 32'h600, 32'h12345678});
      step();
      checkOutput("full write occ", occ, 4);
      applyStimulus(1, 0, 0, 0, 0);
      slvIf.resp = 1'b1; slvIf.rdata = 32'h20;
      rspQ.push_back('{1'b0, 32'h20});
      accQ.push_back('{1'b0, 1'b0, 32'h410, 32'h0});
      #1;
      checkOutput("full holdoff resp", slvIf.req, 0);
      step();
      slvIf.resp = 1'b0;
      checkOutput("after pop occ", occ, 3);
      step();
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("refill occ", occ, 4);
      for (int i = 1; i < 4; i++) begin
         slvIf.resp = 1'b1; slvIf.rdata = 32'h20 + 32'(i);
         rspQ.push_back('{1'b0, 32'h20 + 32'(i)});
         step();
      end
      checkOutput("drain occ", occ, 1);

      // Read accepted in the same cycle a response pops.
      slvIf.rdata = 32'h24;
      rspQ.push_back('{1'b0, 32'h24});
      applyStimulus(1, 1, 0, 32'h500, 0);
      accQ.push_back('{1'b1, 1'b0, 32'h500, 32'h0});
      step();
      checkOutput("push+pop occ", occ, 1);
      applyStimulus(1, 0, 0, 0, 0);
      slvIf.rdata = 32'h77;
      rspQ.push_back('{1'b1, 32'h77});
      step();
      slvIf.resp = 1'b0;
      checkOutput("push+pop drain occ", occ, 0);

      // Stray response with nothing outstanding.
      slvIf.resp = 1'b1; slvIf.rdata = 32'h99;
      #1;
      checkOutput("stray no resp", {m1If.resp, m0If.resp}, 0);
      step();
      slvIf.resp = 1'b0;
      checkOutput("stray err", err, 1);
      step();
      step();
      checkOutput("err sticky", err, 1);

      // Reset with three reads outstanding and m1 locked.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 32'h700 + 32'(4 * i), 0);
         accQ.push_back('{1'b0, 1'b0, 32'h700 + 32'(4 * i), 32'h0});
         step();
      end
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("pre-reset occ", occ, 3);
      slvIf.ack = 1'b0;
      applyStimulus(1, 1, 0, 32'h800, 0);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("mid reset occ", occ, 0);
      checkOutput("mid reset err", err, 0);
      slvIf.resp = 1'b1; slvIf.rdata = 32'h66;
      #1;
      checkOutput("post-reset stray no resp", {m1If.resp, m0If.resp}, 0);
      step();
      slvIf.resp = 1'b0;
      checkOutput("post-reset stray err", err, 1);
      slvIf.ack = 1'b1;
      applyStimulus(0, 1, 0, 32'h900, 0);
      applyStimulus(1, 1, 0, 32'h904, 0);
      accQ.push_back('{1'b0, 1'b0, 32'h900, 32'h0});
      step();
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("post-reset rr occ", occ, 1);
      slvIf.resp = 1'b1; slvIf.rdata = 32'hC3;
      rspQ.push_back('{1'b0, 32'hC3});
      step();
      slvIf.resp = 1'b0;
      checkOutput("final occ", occ, 0);
      step();
      checkOutput("accept queue empty", accQ.size(), 0);
      checkOutput("resp queue empty", rspQ.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
